ieee_multiplier: RTL
====================

Name: ieee_multiplier

Overview:
- Multi-cycle IEEE-754 single-precision multiplier. It is the inverse-operation companion to the FPU's iterative divider.
- Operands are captured on a start handshake. The 24x24 significand product is formed by a shift-add loop, one bit per cycle. The result is then normalised and packed.
- It sits beside the divider in the FPU datapath and is driven by the same issue logic.

Parameters:
- MANT_W, 24, significand width including the hidden bit.
- EXP_W, 8, exponent field width.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- num1  input  32  multiplicand, IEEE single.
- num2  input  32  multiplier, IEEE single.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result valid this cycle and held afterwards.
- result  output  32  packed IEEE single product.
- overflow  output  1  sticky per operation; set with done when the result saturated to infinity.

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE.
  - result=0, done=0, busy=0, overflow=0.
  - Internal accumulator, counter and operand registers cleared.
  - Reset mid-operation abandons the operation; no done is issued.
- FSM states: IDLE, MULT, NORM, DONE.
- IDLE:
  - start=1 captures num1/num2 at cycle 0.
  - Captures sign=num1[31]^num2[31], exponent sum e=num1[30:23]+num2[30:23] (10-bit signed), and significands {1,frac}.
  - Clears the accumulator and moves to MULT.
- MULT, cycles 1..24:
  - If the multiplier LSB is 1, add the multiplicand into the 48-bit accumulator.
  - Shift the multiplier right and the multiplicand left. A 5-bit counter counts 24 iterations, then the FSM moves to NORM.
- NORM, cycle 25:
  - If p[47]=1: fraction=p[46:24], e=e-BIAS+1.
  - Else: fraction=p[45:23], e=e-BIAS.
  - Default rounding is truncation.
- DONE, cycle 26:
  - result registered, done=1 for one cycle, busy=0.
  - Next state is IDLE; start is sampled again from cycle 27.
- Latency: 26 cycles from start acceptance to done. Throughput is one operation per 27 cycles.
- start while busy is ignored and is not queued. num1/num2 may change after cycle 0.
- Special operands, resolved at capture. The FSM still walks all states so latency is fixed.
  - Exponent field 0 (zero or denormal, denormals treated as zero) multiplied by a finite value gives signed zero {sign,31'b0}.
  - Exponent field 255 with nonzero fraction (NaN), or inf*0, gives 32'h7FC00000.
  - inf * finite-nonzero gives {sign,8'hFF,23'b0}.
- Overflow: final e>=255 gives {sign,8'hFF,23'b0} and overflow=1.
- Underflow: final e<=0 gives signed zero (flush-to-zero).
- overflow is cleared on the next start acceptance.

Optional Feature:
- Macro: IEEE_MUL_ROUND_NEAREST_EN.
- Defined: NORM applies round-to-nearest-even using guard, round and sticky bits taken from the discarded product bits.
  - Round-up carry out of the fraction renormalises: fraction=0, e+1.
  - Overflow is checked after rounding.
  - One extra ROUND state is added after NORM, so latency is 27 cycles.
- Undefined: truncation only, latency 26 cycles.

Decomposition:
- Shared package fp_pkg:
  - Constants FP_BIAS, FP_EXP_W, FP_FRAC_W, FP_QNAN (32'h7FC00000).
  - A packed struct fp32_t {sign, exp, frac}.
  - State enum mul_state_e {IDLE, MULT, NORM, ROUND, DONE}.
- One sub-module: mantissa_mult_24bit. It holds the iterative shift-add core: accumulator, counter, load/step inputs, finish flag.
- The top holds sign/exponent handling, the FSM, special-case handling and packing.

Test Plan:
- 0x3FC00000 * 0x40000000 (1.5*2.0) -> result 0x40400000; done exactly 26 cycles after start.
- 0x40400000 * 0x40400000 (3*3) -> 0x41100000. 0xC0000000 * 0x3F000000 (-2*0.5) -> 0xBF800000.
- 0x7F000000 * 0x7F000000 -> 0x7F800000 with overflow=1. 0x80000000 * 0x40400000 -> 0x80000000. 0x7F800000 * 0x00000000 -> 0x7FC00000.
- 0x3F800001 * 0x3FC00000 (tie case):
  - Without the macro -> 0x3FC00001.
  - With IEEE_MUL_ROUND_NEAREST_EN -> 0x3FC00002, done at cycle 27.
- start pulsed again at cycle 10 with different operands -> ignored; first result unchanged; busy stays high.
- rstn pulled low at cycle 12, then released -> result=0, done never pulses; a new start afterwards completes normally.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FPU definitions: IEEE-754 single-precision field widths, bias, the
// canonical quiet NaN, a field view of a packed single, and the multiplier
// FSM state encoding.
package fp_pkg;

    localparam int          FP_BIAS   = 127;
    localparam int          FP_EXP_W  = 8;
    localparam int          FP_FRAC_W = 23;
    localparam logic [31:0] FP_QNAN   = 32'h7FC00000;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        NORM,
        ROUND,
        DONE
    } mul_state_e;

endpackage

// File: rtl/mantissa_mult_24bit.sv
// Iterative shift-add significand multiplier, one multiplier bit per step.
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   i_load          clear accumulator/counter and capture both significands
//   i_step          perform one shift-add iteration
//   i_mcand         multiplicand significand (hidden bit included)
//   i_mplier        multiplier significand (hidden bit included)
//   o_product       accumulated product
//   o_finish        high while the final iteration is being performed
module mantissa_mult_24bit #(
    parameter int MANT_W = 24
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [MANT_W-1:0]     i_mcand,
    input  logic [MANT_W-1:0]     i_mplier,
    output logic [2*MANT_W-1:0]   o_product,
    output logic                  o_finish
);

    localparam int CNT_W = $clog2(MANT_W + 1);

    logic [2*MANT_W-1:0] r_acc;
    logic [2*MANT_W-1:0] r_mcand;
    logic [MANT_W-1:0]   r_mplier;
    logic [CNT_W-1:0]    r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= {{MANT_W{1'b0}}, i_mcand};
            r_mplier <= i_mplier;
            r_cnt    <= '0;
        end else if (i_step) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    assign o_product = r_acc;
    // Counter holds MANT_W-1 during the last of the MANT_W iterations.
    assign o_finish  = (r_cnt == CNT_W'(MANT_W - 1));

endmodule

// File: rtl/ieee_multiplier.sv
// Multi-cycle IEEE-754 single-precision multiplier. Operands are captured on
// start, the significand product is built by mantissa_mult_24bit, then
// normalised, special-cased and packed. Latency is fixed regardless of
// operands.
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   start         request, sampled only when idle
//   num1, num2    IEEE single operands
//   busy          high from the cycle after acceptance until done
//   done          one-cycle pulse, result valid and held afterwards
//   result        packed IEEE single product
//   overflow      set with done when the result saturated to infinity
// Build option: IEEE_MUL_ROUND_NEAREST_EN adds a ROUND state applying
// round-to-nearest-even (latency 27); otherwise truncation (latency 26).
module ieee_multiplier
    import fp_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int EXP_W  = FP_EXP_W,
    parameter int BIAS   = FP_BIAS
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow
);

    localparam int FRAC_W = MANT_W - 1;
    localparam int PROD_W = 2 * MANT_W;
    localparam int E_W    = EXP_W + 2;  // signed working exponent
    localparam logic signed [E_W-1:0] EXP_SAT = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] EXP_MIN = E_W'(1);

    mul_state_e          r_state, w_state_next;
    logic                r_sign, r_special, r_busy, r_done, r_ovf;
    logic [E_W-1:0]      r_exp;
    logic [31:0]         r_special_val, r_result;

    fp32_t               w_a, w_b;
    logic                w_accept, w_sign, w_finish;
    logic                w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
    logic                w_spec, w_pack_ovf;
    logic [31:0]         w_spec_val, w_pack;
    logic [E_W-1:0]      w_exp_sum, w_exp_n, w_exp_fin;
    logic [FRAC_W-1:0]   w_frac_n, w_frac_fin;
    logic [PROD_W-1:0]   w_prod;

    assign w_a      = num1;
    assign w_b      = num2;
    assign w_accept = (r_state == IDLE) && start;
    assign w_sign   = w_a.sign ^ w_b.sign;
    assign w_exp_sum = E_W'(w_a.exp) + E_W'(w_b.exp);

    assign w_a_zero = (w_a.exp == '0);
    assign w_a_inf  = (w_a.exp == '1) && (w_a.frac == '0);
    assign w_a_nan  = (w_a.exp == '1) && (w_a.frac != '0);
    assign w_b_zero = (w_b.exp == '0);
    assign w_b_inf  = (w_b.exp == '1) && (w_b.frac == '0);
    assign w_b_nan  = (w_b.exp == '1) && (w_b.frac != '0);

    // Special operands are resolved at capture; denormals count as zero.
    always_comb begin
        w_spec     = 1'b1;
        w_spec_val = FP_QNAN;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_spec_val = FP_QNAN;
        end else if (w_a_inf || w_b_inf) begin
            w_spec_val = {w_sign, 8'hFF, 23'b0};
        end else if (w_a_zero || w_b_zero) begin
            w_spec_val = {w_sign, 31'b0};
        end else begin
            w_spec = 1'b0;
        end
    end

    mantissa_mult_24bit #(
        .MANT_W (MANT_W)
    ) u_mant (
        .clk       (clk),
        .rstn      (rstn),
        .i_load    (w_accept),
        .i_step    (r_state == MULT),
        .i_mcand   ({1'b1, w_a.frac}),
        .i_mplier  ({1'b1, w_b.frac}),
        .o_product (w_prod),
        .o_finish  (w_finish)
    );

    // Product of two [1,2) significands lies in [1,4); bit PROD_W-1 flags [2,4).
    always_comb begin
        if (w_prod[PROD_W-1]) begin
            w_frac_n = w_prod[PROD_W-2 -: FRAC_W];
            w_exp_n  = r_exp - E_W'(BIAS) + E_W'(1);
        end else begin
            w_frac_n = w_prod[PROD_W-3 -: FRAC_W];
            w_exp_n  = r_exp - E_W'(BIAS);
        end
    end

`ifdef IEEE_MUL_ROUND_NEAREST_EN
    localparam mul_state_e LAST_ST = ROUND;

    logic [FRAC_W-1:0] r_frac, w_frac_rnd;
    logic [3:0]        r_grs, w_grs_n;  // {lsb, guard, round, sticky}
    logic              w_round_up, w_carry;

    assign w_grs_n = w_prod[PROD_W-1]
        ? {w_prod[MANT_W], w_prod[MANT_W-1], w_prod[MANT_W-2], |w_prod[MANT_W-3:0]}
        : {w_prod[MANT_W-1], w_prod[MANT_W-2], w_prod[MANT_W-3], |w_prod[MANT_W-4:0]};

    // Ties go to the even fraction.
    assign w_round_up = r_grs[2] & (r_grs[3] | r_grs[1] | r_grs[0]);
    assign {w_carry, w_frac_rnd} = {1'b0, r_frac} + {{FRAC_W{1'b0}}, w_round_up};
    // Carry out means the significand rounded up to 2.0.
    assign w_frac_fin = w_carry ? '0 : w_frac_rnd;
    assign w_exp_fin  = r_exp + {{(E_W-1){1'b0}}, w_carry};
`else
    localparam mul_state_e LAST_ST = NORM;

    logic w_unused;
    // Discarded product bits only matter when rounding.
    assign w_unused   = ^w_prod[MANT_W-2:0];
    assign w_frac_fin = w_frac_n;
    assign w_exp_fin  = w_exp_n;
`endif

    always_comb begin
        w_pack_ovf = 1'b0;
        if (r_special) begin
            w_pack = r_special_val;
        end else if ($signed(w_exp_fin) >= EXP_SAT) begin
            w_pack     = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            w_pack_ovf = 1'b1;
        end else if ($signed(w_exp_fin) < EXP_MIN) begin
            w_pack = {r_sign, 31'b0};
        end else begin
            w_pack = {r_sign, w_exp_fin[EXP_W-1:0], w_frac_fin};
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_next = MULT;
            MULT:    if (w_finish) w_state_next = NORM;
`ifdef IEEE_MUL_ROUND_NEAREST_EN
            NORM:    w_state_next = ROUND;
`else
            NORM:    w_state_next = DONE;
`endif
            ROUND:   w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_sign        <= 1'b0;
            r_exp         <= '0;
            r_special     <= 1'b0;
            r_special_val <= '0;
            r_result      <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_ovf         <= 1'b0;
`ifdef IEEE_MUL_ROUND_NEAREST_EN
            r_frac        <= '0;
            r_grs         <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            if (w_accept) begin
                r_sign        <= w_sign;
                r_exp         <= w_exp_sum;
                r_special     <= w_spec;
                r_special_val <= w_spec_val;
                r_busy        <= 1'b1;
                r_ovf         <= 1'b0;
            end
`ifdef IEEE_MUL_ROUND_NEAREST_EN
            if (r_state == NORM) begin
                r_exp  <= w_exp_n;
                r_frac <= w_frac_n;
                r_grs  <= w_grs_n;
            end
`endif
            if (r_state == LAST_ST) begin
                r_result <= w_pack;
                r_ovf    <= w_pack_ovf;
                r_done   <= 1'b1;
                r_busy   <= 1'b0;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign overflow = r_ovf;

endmodule
